// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter granting one of P_NUM_REQ byte
// requesters access to a single UART TX port. A grant is held for a whole
// packet (until i_req_last) or until P_MAX_BURST bytes have gone through.
// Optional macro UART_TX_ARB_TIMEOUT_EN adds a stall watchdog that force-
// releases an owner which stops presenting data for P_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int P_NUM_REQ    = 4,
  parameter int P_DATA_WIDTH = 8,
  parameter int P_MAX_BURST  = 16,
  parameter int P_TIMEOUT    = 255
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [P_NUM_REQ-1:0]              i_req_valid,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_NUM_REQ-1:0]              i_req_last,
  output logic [P_NUM_REQ-1:0]              o_req_ready,
  output logic [P_DATA_WIDTH-1:0]           o_tx_data,
  output logic                              o_tx_valid,
  input  logic                              i_tx_ready,
  output logic [P_NUM_REQ-1:0]              o_grant,
  output logic                              o_busy,
  output logic                              o_timeout
);

  localparam int IW = $clog2(P_NUM_REQ);
  localparam int CW = IW + 1;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                               state, state_nxt;
  logic [IW-1:0]                        grant_idx, last_ptr, arb_idx;
  logic [CW-1:0]                        arb_cand;
  logic                                 arb_found;
  logic [7:0]                           burst_cnt;
  logic [P_NUM_REQ-1:0][P_DATA_WIDTH-1:0] req_data;
  logic                                 own_valid, own_last;
  logic                                 xfer_fire, burst_done, stall_hit, release_grant;

  assign req_data   = i_req_data;
  assign own_valid  = i_req_valid[grant_idx];
  assign own_last   = i_req_last[grant_idx];
  assign xfer_fire  = (state == XFER) && own_valid && i_tx_ready;
  assign burst_done = ({1'b0, burst_cnt} + 9'd1) == 9'(P_MAX_BURST);
  // last byte and burst limit on the same transfer collapse into one release
  assign release_grant = (xfer_fire && (own_last || burst_done)) || stall_hit;

  // Round-robin search: first valid requester above last_ptr, wrapping
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int i = 1; i <= P_NUM_REQ; i++) begin
      arb_cand = {1'b0, last_ptr} + CW'(i);
      if (arb_cand >= CW'(P_NUM_REQ)) arb_cand = arb_cand - CW'(P_NUM_REQ);
      if (!arb_found && i_req_valid[arb_cand[IW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand[IW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: grant on any request, release on last/burst/stall
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_found)     state_nxt = XFER;
      XFER:    if (release_grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Owner, round-robin pointer and burst counter
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_idx <= '0;
      last_ptr  <= IW'(P_NUM_REQ - 1);
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      burst_cnt <= '0;
      if (arb_found) grant_idx <= arb_idx;
    end else begin
      if (xfer_fire)     burst_cnt <= burst_cnt + 8'd1;
      if (release_grant) last_ptr  <= grant_idx;
    end
  end

  // FSM outputs: owner's byte passes straight through while in XFER
  always_comb begin
    o_busy     = (state == XFER);
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    if (state == XFER) begin
      o_tx_valid = own_valid;
      o_tx_data  = req_data[grant_idx];
    end
  end

  // Per-requester grant decode and ready steering
  for (genvar k = 0; k < P_NUM_REQ; k++) begin : g_lane
    assign o_grant[k]     = (state == XFER) && (grant_idx == IW'(k));
    assign o_req_ready[k] = o_grant[k] & i_tx_ready;
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt;

  assign stall_hit = (state == XFER) && !own_valid &&
                     (({1'b0, stall_cnt} + 17'd1) == 17'(P_TIMEOUT));

  // Stall watchdog: counts owner-idle cycles, pulses o_timeout on release
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= stall_hit;
      if (state != XFER || own_valid) stall_cnt <= '0;
      else                            stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_hit = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (4 requesters, burst 4, timeout 8). Byte sources
// are per-requester queues; expected bytes with their owner go into a
// scoreboard in the order the arbitration should deliver them.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  i_req_valid, i_req_last, o_req_ready, o_grant;
  logic [31:0] i_req_data;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid, i_tx_ready, o_busy, o_timeout;

  typedef struct {int idx; logic [7:0] d;} exp_t;

  exp_t       sb [$];
  logic [8:0] src [4][$];
  int         n_cmp = 0;
  int         n_err = 0;

  uart_tx_arbiter #(
    .P_NUM_REQ(4), .P_DATA_WIDTH(8), .P_MAX_BURST(4), .P_TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .i_req_last(i_req_last),
    .o_req_ready(o_req_ready), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .i_tx_ready(i_tx_ready), .o_grant(o_grant), .o_busy(o_busy),
    .o_timeout(o_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic q_src(input int k, input logic [7:0] d, input logic l);
    src[k].push_back({l, d});
  endtask

  task automatic q_exp(input int k, input logic [7:0] d);
    exp_t e;
    e.idx = k;
    e.d   = d;
    sb.push_back(e);
  endtask

  // Present the head of each source queue
  task automatic drive();
    logic [8:0] f;
    for (int k = 0; k < 4; k++) begin
      if (src[k].size() > 0) begin
        f = src[k][0];
        i_req_valid[k]        = 1'b1;
        i_req_last[k]         = f[8];
        i_req_data[k*8 +: 8]  = f[7:0];
      end else begin
        i_req_valid[k]        = 1'b0;
        i_req_last[k]         = 1'b0;
        i_req_data[k*8 +: 8]  = 8'h00;
      end
    end
  endtask

  // One clock: check the byte leaving the DUT, then advance the sources
  task automatic step();
    logic [3:0] acc;
    exp_t       e;
    #1;
    if (o_tx_valid && i_tx_ready && !reset) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'(o_tx_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("tx_data", 32'(o_tx_data), 32'(e.d));
        chk("tx_owner", 32'(o_grant), 32'd1 << e.idx);
      end
    end
    acc = reset ? 4'b0 : (o_req_ready & i_req_valid);
    @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++) if (acc[k]) src[k].delete(0);
    drive();
    @(negedge clock);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (sb.size() > 0 && n < max) begin
      step();
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_grant",  32'(o_grant),     32'd0);
    chk("rst_busy",   32'(o_busy),      32'd0);
    chk("rst_txv",    32'(o_tx_valid),  32'd0);
    chk("rst_txd",    32'(o_tx_data),   32'd0);
    chk("rst_ready",  32'(o_req_ready), 32'd0);
    chk("rst_tmo",    32'(o_timeout),   32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    i_tx_ready  = 1'b1;
    drive();
    step();
    step();
    chk_reset_outs();
    reset = 1'b0;

    // Two packets pending: requester 1 wins first after reset
    q_src(1, 8'h41, 1'b0); q_src(1, 8'h42, 1'b0); q_src(1, 8'h43, 1'b1);
    q_src(2, 8'h51, 1'b0); q_src(2, 8'h52, 1'b1);
    q_exp(1, 8'h41); q_exp(1, 8'h42); q_exp(1, 8'h43);
    q_exp(2, 8'h51); q_exp(2, 8'h52);
    drive();
    step();
    chk("first_grant", 32'(o_grant), 32'h2);
    chk("first_busy",  32'(o_busy),  32'd1);
    chk("first_ready", 32'(o_req_ready), 32'h2);
    step(); step(); step();
    chk("gap_grant", 32'(o_grant), 32'd0);
    chk("gap_busy",  32'(o_busy),  32'd0);
    step();
    chk("second_grant", 32'(o_grant), 32'h4);
    drain(20);

    // Reset in the middle of a packet from requester 3
    q_src(3, 8'hA0, 1'b0); q_src(3, 8'hA1, 1'b0);
    q_src(3, 8'hA2, 1'b0); q_src(3, 8'hA3, 1'b1);
    q_exp(3, 8'hA0);
    drive();
    step();
    chk("r3_grant", 32'(o_grant), 32'h8);
    step();
    reset = 1'b1;
    step();
    chk_reset_outs();
    reset = 1'b0;
    q_src(0, 8'hB0, 1'b1);
    q_exp(0, 8'hB0);
    q_exp(3, 8'hA1); q_exp(3, 8'hA2); q_exp(3, 8'hA3);
    drive();
    step();
    chk("post_rst_grant", 32'(o_grant), 32'h1);
    drain(30);

    // Burst limit with a ready stall in the middle of the burst
    for (int b = 0; b < 10; b++) q_src(0, 8'(b), 1'b0);
    for (int b = 0; b < 4; b++)  q_exp(0, 8'(b));
    drive();
    step();
    chk("burst_grant", 32'(o_grant), 32'h1);
    q_src(3, 8'hD0, 1'b1);
    q_exp(3, 8'hD0);
    for (int b = 4; b < 10; b++) q_exp(0, 8'(b));
    drive();
    step(); step();
    i_tx_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("stall_ready", 32'(o_req_ready), 32'd0);
      chk("stall_txd",   32'(o_tx_data),   32'h2);
      chk("stall_grant", 32'(o_grant),     32'h1);
    end
    i_tx_ready = 1'b1;
    step(); step();
    chk("burst_rel_grant", 32'(o_grant), 32'd0);
    step();
    chk("burst_next_grant", 32'(o_grant), 32'h8);
    drain(60);

    // Owner 0 now holds the grant with nothing to send
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int c = 0; c < 7; c++) begin
      step();
      chk("tmo_wait", 32'(o_timeout), 32'd0);
      chk("tmo_hold", 32'(o_grant),   32'h1);
    end
    step();
    chk("tmo_pulse", 32'(o_timeout), 32'd1);
    chk("tmo_grant", 32'(o_grant),   32'd0);
    step();
    chk("tmo_once",  32'(o_timeout), 32'd0);
`else
    for (int c = 0; c < 9; c++) begin
      step();
      chk("hold_tmo",   32'(o_timeout), 32'd0);
      chk("hold_grant", 32'(o_grant),   32'h1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
